// File: rtl/line_pkg.sv
// Shared types and default geometry for the line raster engine.
// Coordinates are unsigned; colour is packed {r,g,b}.
package line_pkg;

  localparam int XW       = 11;
  localparam int YW       = 10;
  localparam int CW       = 12;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  typedef struct packed {
    logic [XW-1:0] x0;
    logic [YW-1:0] y0;
    logic [XW-1:0] x1;
    logic [YW-1:0] y1;
    logic [CW-1:0] color;
  } line_cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAW,
    DONE
  } state_t;

endpackage

// File: rtl/line_cmd_fifo.sv
// Synchronous command FIFO with full/empty/level.
// Push while full and pop while empty are ignored.
module line_cmd_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  T                         din,
  output T                         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          wr_en, rd_en;
  T              mem [DEPTH];

  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign level = cnt_q;
  assign dout  = mem[rd_q];
  assign wr_en = push & ~full;
  assign rd_en = pop & ~empty;

  // Pointer and occupancy update.
  always_comb begin
    wr_d  = wr_q + AW'(wr_en);
    rd_d  = rd_q + AW'(rd_en);
    cnt_d = cnt_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_q] <= din;
  end

endmodule

// File: rtl/line_raster_engine.sv
// Bresenham line rasteriser: command FIFO, FSM, stepping datapath.
// Emits a valid/ready pixel stream with optional active-area clipping.
module line_raster_engine
  import line_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter bit CLIP_EN  = 1'b1,
  parameter int H_ACTIVE = line_pkg::H_ACTIVE,
  parameter int V_ACTIVE = line_pkg::V_ACTIVE
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [XW-1:0]          cmd_x0,
  input  logic [YW-1:0]          cmd_y0,
  input  logic [XW-1:0]          cmd_x1,
  input  logic [YW-1:0]          cmd_y1,
  input  logic [CW-1:0]          cmd_color,
  output logic                   pix_valid,
  input  logic                   pix_ready,
  output logic [XW-1:0]          pix_x,
  output logic [YW-1:0]          pix_y,
  output logic [CW-1:0]          pix_color,
  output logic                   pix_last,
  output logic                   start_mark,
  output logic                   done_mark,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int W = ((XW > YW) ? XW : YW) + 2;
  localparam logic [XW-1:0] H_LIM = XW'(H_ACTIVE);
  localparam logic [YW-1:0] V_LIM = YW'(V_ACTIVE);

  state_t    state_q, state_d;
  line_cmd_t cmd_q, cmd_d;
  line_cmd_t fifo_din, fifo_dout;
  logic      fifo_full, fifo_empty, push, pop;

  logic [XW-1:0]       x_q, x_d;
  logic [YW-1:0]       y_q, y_d;
  logic signed [W-1:0] dx_q, dx_d;
  logic signed [W-1:0] dy_q, dy_d;
  logic signed [W-1:0] err_q, err_d;
  logic                sx_q, sx_d;
  logic                sy_q, sy_d;

  logic signed [W-1:0] x0e, x1e, y0e, y1e;
  logic signed [W-1:0] dx_abs, dy_abs, e2;
  logic                clipped, is_last, step;

  assign fifo_din = '{cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color};
  assign push     = cmd_valid & ~fifo_full;

  line_cmd_fifo #(
    .DEPTH(DEPTH),
    .T    (line_cmd_t)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .din  (fifo_din),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty),
    .level(fifo_level)
  );

  assign x0e    = $signed({{(W-XW){1'b0}}, cmd_q.x0});
  assign x1e    = $signed({{(W-XW){1'b0}}, cmd_q.x1});
  assign y0e    = $signed({{(W-YW){1'b0}}, cmd_q.y0});
  assign y1e    = $signed({{(W-YW){1'b0}}, cmd_q.y1});
  assign dx_abs = (x1e >= x0e) ? x1e - x0e : x0e - x1e;
  assign dy_abs = (y1e >= y0e) ? y1e - y0e : y0e - y1e;
  assign e2     = err_q <<< 1;

  assign clipped = CLIP_EN && ((x_q >= H_LIM) || (y_q >= V_LIM));
  assign is_last = (x_q == cmd_q.x1) && (y_q == cmd_q.y1);
  assign step    = (state_q == DRAW) && (clipped || pix_ready);

  assign cmd_ready  = ~fifo_full;
  assign pix_valid  = (state_q == DRAW) && !clipped;
  assign pix_last   = pix_valid && is_last;
  assign pix_x      = x_q;
  assign pix_y      = y_q;
  assign pix_color  = cmd_q.color;
  assign start_mark = (state_q == LOAD);
  assign done_mark  = (state_q == DONE);
  assign busy       = (state_q != IDLE) || !fifo_empty;

  // Next state, command capture and Bresenham stepping.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    x_d     = x_q;
    y_d     = y_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    err_d   = err_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          cmd_d   = fifo_dout;
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        x_d     = cmd_q.x0;
        y_d     = cmd_q.y0;
        dx_d    = dx_abs;
        dy_d    = -dy_abs;
        err_d   = dx_abs - dy_abs;
        sx_d    = (cmd_q.x1 < cmd_q.x0);
        sy_d    = (cmd_q.y1 < cmd_q.y0);
        state_d = DRAW;
      end
      DRAW: begin
        if (step) begin
          if (is_last) begin
            state_d = DONE;
          end else begin
            if (e2 >= dy_q) begin
              err_d = err_d + dy_q;
              x_d   = sx_q ? x_q - XW'(1) : x_q + XW'(1);
            end
            if (e2 <= dx_q) begin
              err_d = err_d + dx_q;
              y_d   = sy_q ? y_q - YW'(1) : y_q + YW'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      err_q   <= '0;
      sx_q    <= 1'b0;
      sy_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      err_q   <= err_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
    end
  end

endmodule

// File: tb/tb_line_raster_engine.sv
// Scoreboard bench for line_raster_engine.
// Expected pixels come from a Bresenham reference walk.
module tb_line_raster_engine;
  import line_pkg::*;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready;
  logic [XW-1:0] cmd_x0, cmd_x1;
  logic [YW-1:0] cmd_y0, cmd_y1;
  logic [CW-1:0] cmd_color;
  logic          pix_valid, pix_ready, pix_last;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic [CW-1:0] pix_color;
  logic          start_mark, done_mark, busy;
  logic [LW-1:0] fifo_level;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] c;
    logic          last;
  } pix_t;

  pix_t          exp_q[$];
  logic [XW-1:0] got_x[$];
  logic [YW-1:0] got_y[$];

  int passed = 0, total = 0, cyc = 0;
  int pix_cnt, last_cnt, start_cnt, done_cnt;
  int start_cyc, done_cyc, first_cyc, stall_cnt;
  bit seen_first, hold_chk;
  bit sb_en = 1'b1;
  int rdy_mode = 0, rdy_ph = 0;
  pix_t held;
  logic held_v;

  line_raster_engine #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_x0    (cmd_x0),
    .cmd_y0    (cmd_y0),
    .cmd_x1    (cmd_x1),
    .cmd_y1    (cmd_y1),
    .cmd_color (cmd_color),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_color (pix_color),
    .pix_last  (pix_last),
    .start_mark(start_mark),
    .done_mark (done_mark),
    .busy      (busy),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: pix_ready = 1'b1;
      1: begin
        pix_ready = (rdy_ph == 0) || (rdy_ph == 3);
        rdy_ph = (rdy_ph + 1) % 4;
      end
      default: pix_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (!reset) begin
      hold_chk = 1'b0;
    end else begin
      if (start_mark) begin start_cnt++; start_cyc = cyc; end
      if (done_mark) begin done_cnt++; done_cyc = cyc; end
      if (hold_chk) begin
        total++;
        stall_cnt++;
        if (pix_valid !== held_v || pix_x !== held.x || pix_y !== held.y ||
            pix_color !== held.c || pix_last !== held.last) begin
          $display("FAIL stall_hold got v=%b x=%0d y=%0d c=%h l=%b want v=%b x=%0d y=%0d c=%h l=%b",
                   pix_valid, pix_x, pix_y, pix_color, pix_last,
                   held_v, held.x, held.y, held.c, held.last);
        end else passed++;
      end
      if (pix_valid && !seen_first) begin
        seen_first = 1'b1;
        first_cyc = cyc;
      end
      if (pix_valid && pix_ready && sb_en) begin
        pix_t e;
        pix_cnt++;
        if (pix_last) last_cnt++;
        got_x.push_back(pix_x);
        got_y.push_back(pix_y);
        total++;
        if (exp_q.size() == 0) begin
          $display("FAIL pixel_extra got x=%0d y=%0d want none", pix_x, pix_y);
        end else begin
          e = exp_q.pop_front();
          if (pix_x !== e.x || pix_y !== e.y || pix_color !== e.c || pix_last !== e.last)
            $display("FAIL pixel got x=%0d y=%0d c=%h l=%b want x=%0d y=%0d c=%h l=%b",
                     pix_x, pix_y, pix_color, pix_last, e.x, e.y, e.c, e.last);
          else passed++;
        end
      end
      hold_chk = pix_valid && !pix_ready;
      held_v   = pix_valid;
      held     = '{pix_x, pix_y, pix_color, pix_last};
    end
  end

  task automatic model_line(input int x0, y0, x1, y1, c);
    int dx, dy, sx, sy, err, e2, x, y;
    dx  = (x1 > x0) ? x1 - x0 : x0 - x1;
    dy  = -((y1 > y0) ? y1 - y0 : y0 - y1);
    sx  = (x0 < x1) ? 1 : -1;
    sy  = (y0 < y1) ? 1 : -1;
    err = dx + dy;
    x   = x0;
    y   = y0;
    for (int n = 0; n < 4096; n++) begin
      if (x < H_ACTIVE && y < V_ACTIVE) begin
        pix_t p;
        p.x = XW'(x);
        p.y = YW'(y);
        p.c = CW'(c);
        p.last = (x == x1) && (y == y1);
        exp_q.push_back(p);
      end
      if (x == x1 && y == y1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endtask

  task automatic push_cmd(input int x0, y0, x1, y1, c, input bit mdl,
                          output int pcyc);
    int n = 0;
    while (!cmd_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!cmd_ready) begin
      total++;
      $display("FAIL push_wait cmd_ready=%b want 1", cmd_ready);
    end
    if (mdl) model_line(x0, y0, x1, y1, c);
    cmd_x0    = XW'(x0);
    cmd_y0    = YW'(y0);
    cmd_x1    = XW'(x1);
    cmd_y1    = YW'(y1);
    cmd_color = CW'(c);
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    pcyc = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || exp_q.size() != 0) && n < 3000);
    total++;
    if (busy || exp_q.size() != 0)
      $display("FAIL %s_timeout busy=%b left=%0d want 0/0", name, busy, exp_q.size());
    else passed++;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    pix_cnt = 0; last_cnt = 0; start_cnt = 0; done_cnt = 0;
    start_cyc = 0; done_cyc = 0; first_cyc = 0; stall_cnt = 0;
    seen_first = 1'b0;
    got_x.delete();
    got_y.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cmd_valid = 1'b0;
    pix_ready = 1'b1;
    cmd_x0 = '0; cmd_y0 = '0; cmd_x1 = '0; cmd_y1 = '0; cmd_color = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({pix_valid, pix_last, start_mark, done_mark, busy} !== 5'b0)
      $display("FAIL reset_flags got %b want 00000",
               {pix_valid, pix_last, start_mark, done_mark, busy});
    else passed++;
    total++;
    if (fifo_level !== '0 || pix_x !== '0 || pix_y !== '0 || pix_color !== '0)
      $display("FAIL reset_data lvl=%0d x=%0d y=%0d c=%h want 0", fifo_level,
               pix_x, pix_y, pix_color);
    else passed++;
    reset = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (cmd_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", cmd_ready);
    else passed++;
  endtask

  task automatic test_t1();
    int pc;
    clear_stats();
    push_cmd(3, 0, 12, 4, 'h123, 1'b1, pc);
    wait_idle("t1");
    total++;
    if (pix_cnt != 10 || last_cnt != 1)
      $display("FAIL t1_count got %0d/%0d want 10/1", pix_cnt, last_cnt);
    else passed++;
    total++;
    if (got_x.size() != 10 || got_x[0] != 3 || got_x[9] != 12 || got_y[9] != 4)
      $display("FAIL t1_ends got n=%0d want x 3..12 y end 4", got_x.size());
    else passed++;
    total++;
    if (done_cnt != 1 || done_cyc != start_cyc + 11)
      $display("FAIL t1_done got n=%0d dt=%0d want 1/11", done_cnt, done_cyc - start_cyc);
    else passed++;
  endtask

  task automatic test_t2();
    int pc;
    bit ok = 1'b1;
    clear_stats();
    push_cmd(50, 0, 90, 30, 'h0f0, 1'b1, pc);
    wait_idle("t2");
    total++;
    if (pix_cnt != 41) $display("FAIL t2_count got %0d want 41", pix_cnt);
    else passed++;
    total++;
    if (first_cyc != pc + 2) $display("FAIL t2_latency got %0d want 2", first_cyc - pc);
    else passed++;
    for (int i = 1; i < got_x.size(); i++)
      if (got_x[i] != got_x[i-1] + 1 || got_y[i] < got_y[i-1]) ok = 1'b0;
    total++;
    if (!ok || got_y.size() != 41 || got_y[0] != 0 || got_y[40] != 30)
      $display("FAIL t2_shape got ok=%b n=%0d want 1/41", ok, got_y.size());
    else passed++;
  endtask

  task automatic test_t3();
    int pc;
    clear_stats();
    push_cmd(10, 10, 2, 14, 'h00f, 1'b1, pc);
    wait_idle("t3");
    total++;
    if (pix_cnt != 9 || got_x.size() != 9 || got_x[0] != 10 || got_x[8] != 2 ||
        got_y[8] != 14)
      $display("FAIL t3_walk got n=%0d want 9 x 10..2 y 10..14", pix_cnt);
    else passed++;
  endtask

  task automatic test_t4();
    int pc;
    clear_stats();
    push_cmd(5, 5, 5, 5, 'hfff, 1'b1, pc);
    wait_idle("t4");
    total++;
    if (pix_cnt != 1 || last_cnt != 1 || start_cnt != 1 || done_cnt != 1)
      $display("FAIL t4_single got px=%0d l=%0d s=%0d d=%0d want 1/1/1/1",
               pix_cnt, last_cnt, start_cnt, done_cnt);
    else passed++;
  endtask

  task automatic test_t5();
    int pc;
    clear_stats();
    rdy_ph = 0;
    rdy_mode = 1;
    push_cmd(50, 0, 90, 30, 'h5a5, 1'b1, pc);
    wait_idle("t5");
    rdy_mode = 0;
    total++;
    if (pix_cnt != 41 || stall_cnt == 0)
      $display("FAIL t5_backpressure got n=%0d stalls=%0d want 41/>0", pix_cnt, stall_cnt);
    else passed++;
  endtask

  task automatic test_t6();
    int pc;
    clear_stats();
    sb_en = 1'b0;
    rdy_mode = 2;
    @(posedge clk);
    #2;
    for (int i = 0; i <= DEPTH; i++) push_cmd(1 + i, 1, 20 + i, 5, 'h111 * i, 1'b0, pc);
    total++;
    if (cmd_ready !== 1'b0 || fifo_level !== LW'(DEPTH) || pix_valid !== 1'b1)
      $display("FAIL t6_full got rdy=%b lvl=%0d v=%b want 0/%0d/1",
               cmd_ready, fifo_level, pix_valid, DEPTH);
    else passed++;
    reset = 1'b0;
    #1;
    total++;
    if (pix_valid !== 1'b0 || fifo_level !== '0 || busy !== 1'b0)
      $display("FAIL t6_reset got v=%b lvl=%0d busy=%b want 0/0/0",
               pix_valid, fifo_level, busy);
    else passed++;
    @(posedge clk);
    #1;
    reset = 1'b1;
    rdy_mode = 0;
    sb_en = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic test_t7();
    int pc;
    clear_stats();
    push_cmd(630, 0, 645, 0, 'habc, 1'b1, pc);
    wait_idle("t7");
    total++;
    if (pix_cnt != 10 || last_cnt != 0 || got_x.size() != 10 || got_x[9] != 639)
      $display("FAIL t7_clip got n=%0d l=%0d want 10/0", pix_cnt, last_cnt);
    else passed++;
    total++;
    if (done_cnt != 1 || done_cyc != start_cyc + 17)
      $display("FAIL t7_done got n=%0d dt=%0d want 1/17", done_cnt, done_cyc - start_cyc);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_t1();
    test_t2();
    test_t3();
    test_t4();
    test_t5();
    test_t6();
    test_t7();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
